hamming_secded_decoder: RTL

- Decodes the team's 16-bit (15+1) Hamming codeword back to 11 data bits.
- Corrects any single-bit error and detects double-bit errors using the overall parity bit in bit 0.
- Sits at the read side of the Hamming storage path, opposite the encoder.
- Two-stage valid/ready pipeline; keeps saturating counters of corrected and uncorrectable words.

---
 rtl/hamming_secded_decoder_if.sv | 30 +++
 rtl/hamming_secded_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hamming_secded_decoder_if.sv
// Decoder port bundle: input codeword handshake, output result handshake, error counters.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the valid-ready flow control for each side.
interface hamming_secded_decoder_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      code_in;
   logic             out_valid;
   logic             out_ready;
   logic [10:0]      data_out;
   logic [1:0]       err_code;
   logic [3:0]       err_pos;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_corr;
   logic [CNT_W-1:0] cnt_uncorr;

   // Producer/consumer side that feeds codewords and drains results.
   modport master (
      output in_valid, code_in, out_ready, cnt_clr,
      input  in_ready, out_valid, data_out, err_code, err_pos, cnt_corr, cnt_uncorr
   );

   // Decoder side.
   modport slave (
      input  in_valid, code_in, out_ready, cnt_clr,
      output in_ready, out_valid, data_out, err_code, err_pos, cnt_corr, cnt_uncorr
   );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Hamming SECDED decoder: 16-bit (15+1) codeword -> 11 data bits, corrects 1 error, flags 2.
// Latency: result 2 cycles after the input handshake; 1 word per cycle throughput.
// Backpressure: out_ready low freezes stage 2; in_ready drops once stage 1 is also occupied.
module hamming_secded_decoder #(
   parameter bit USE_OVERALL_PARITY = 1'b1,
   parameter int CNT_W              = 16
) (
   input logic                     clk,
   input logic                     rst,
   hamming_secded_decoder_if.slave bus
);
   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_CORR   = 2'b01;
   localparam logic [1:0] ERR_UNCORR = 2'b10;

   // Codeword position of each data bit d0..d10.
   localparam logic [3:0] DATA_POS [11] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10,
                                             4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

   typedef struct packed {
      logic [10:0] data;
      logic [1:0]  errCode;
      logic [3:0]  errPos;
   } result_t;

   logic             advance;
   logic             inReady;
   logic             inHs;
   logic             outHs;
   logic [3:0]       synIn;
   logic             parIn;
   logic [10:0]      dataIn;
   logic             s1Valid;
   logic [10:0]      s1Data;
   logic [3:0]       s1Syn;
   logic             s1Par;
   logic [10:0]      flipMask;
   result_t          s2Next;
   result_t          s2Res;
   logic             s2Valid;
   logic [CNT_W-1:0] cntCorr;
   logic [CNT_W-1:0] cntUncorr;

   // Stage 2 moves whenever its current word leaves or it is empty; stage 1 refills behind it.
   assign advance = !s2Valid || bus.out_ready;
   assign inReady = !s1Valid || advance;
   assign inHs    = bus.in_valid && inReady;
   assign outHs   = s2Valid && bus.out_ready;

   // Syndrome bit k is the parity of every position whose index has bit k set.
   always_comb begin
      synIn[0] = ^(bus.code_in & 16'hAAAA);
      synIn[1] = ^(bus.code_in & 16'hCCCC);
      synIn[2] = ^(bus.code_in & 16'hF0F0);
      synIn[3] = ^(bus.code_in & 16'hFF00);
      parIn    = ^bus.code_in;
      dataIn   = {bus.code_in[15:9], bus.code_in[7:5], bus.code_in[3]};
   end

   // Stage 1: capture the data positions plus syndrome/parity; check bits live on in the syndrome.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid <= 1'b0;
         s1Data  <= '0;
         s1Syn   <= '0;
         s1Par   <= 1'b0;
      end else if (inHs) begin
         s1Valid <= 1'b1;
         s1Data  <= dataIn;
         s1Syn   <= synIn;
         s1Par   <= parIn;
      end else if (advance) begin
         s1Valid <= 1'b0;
      end
   end

   // Classify the stage-1 word and build the corrected data; a syndrome at a check-bit position flips no data.
   always_comb begin
      flipMask = '0;
      for (int k = 0; k < 11; k++) begin
         flipMask[k] = (s1Syn == DATA_POS[k]);
      end
      s2Next.data    = s1Data;
      s2Next.errCode = ERR_NONE;
      s2Next.errPos  = '0;
      if (USE_OVERALL_PARITY) begin
         if (s1Par) begin
            s2Next.data    = s1Data ^ flipMask;
            s2Next.errCode = ERR_CORR;
            s2Next.errPos  = s1Syn;
         end else if (s1Syn != 4'd0) begin
            s2Next.errCode = ERR_UNCORR;
         end
      end else if (s1Syn != 4'd0) begin
         s2Next.data    = s1Data ^ flipMask;
         s2Next.errCode = ERR_CORR;
         s2Next.errPos  = s1Syn;
      end
   end

   // Stage 2: result register, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2Valid <= 1'b0;
         s2Res   <= '0;
      end else if (advance) begin
         s2Valid <= s1Valid;
         if (s1Valid) begin
            s2Res <= s2Next;
         end
      end
   end

   // Saturating error counters bumped on each delivered result; clear wins over a same-cycle bump.
   always_ff @(posedge clk) begin
      if (rst || bus.cnt_clr) begin
         cntCorr   <= '0;
         cntUncorr <= '0;
      end else if (outHs) begin
         if (s2Res.errCode == ERR_CORR && cntCorr != {CNT_W{1'b1}}) begin
            cntCorr <= cntCorr + 1'b1;
         end
         if (s2Res.errCode == ERR_UNCORR && cntUncorr != {CNT_W{1'b1}}) begin
            cntUncorr <= cntUncorr + 1'b1;
         end
      end
   end

   assign bus.in_ready   = inReady;
   assign bus.out_valid  = s2Valid;
   assign bus.data_out   = s2Res.data;
   assign bus.err_code   = s2Res.errCode;
   assign bus.err_pos    = s2Res.errPos;
   assign bus.cnt_corr   = cntCorr;
   assign bus.cnt_uncorr = cntUncorr;
endmodule
